// File: rtl/brisc_pkg.sv
// Shared definitions for the BRISC front end: loader states and image-format constants.
package brisc_pkg;

    localparam int          IMEM_DEPTH = 32;
    localparam int          ADDR_W     = 5;
    localparam int          INSTR_W    = 16;
    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SYNC,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if #(
    parameter int INSTR_W = brisc_pkg::INSTR_W,
    parameter int ADDR_W  = brisc_pkg::ADDR_W
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/program_loader_byte_word_packer.sv
// Packs bytes MSB-first into INSTR_W-bit words; word/word_valid are presented with the final byte.
module byte_word_packer #(
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_valid
);
    localparam int BYTES = INSTR_W / 8;

    logic [INSTR_W-1:0] shreg;
    logic [2:0]         cnt;
    logic               last;

    assign last       = (cnt == 3'(BYTES - 1));
    assign word       = (shreg << 8) | INSTR_W'(byte_in);
    assign word_valid = byte_valid && last;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (byte_valid) begin
            if (last) begin
                shreg <= '0;
                cnt   <= '0;
            end else begin
                shreg <= word;
                cnt   <= cnt + 3'd1;
            end
        end
    end
endmodule

// File: rtl/program_loader.sv
// Receives a framed program image (SYNC, LEN, data, XOR checksum) and writes it into instruction memory.
module program_loader #(
    parameter int         INSTR_W     = brisc_pkg::INSTR_W,
    parameter int         ADDR_W      = brisc_pkg::ADDR_W,
    parameter logic [7:0] SYNC_BYTE   = brisc_pkg::SYNC_BYTE,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    program_loader_if.slave   bus,
    output logic              loading,
    output logic              load_done,
    output logic              load_err
);
    import brisc_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LEN_W = ADDR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    loader_state_t      state, state_n;
    logic [LEN_W-1:0]   len, len_n;
    logic [LEN_W-1:0]   idx, idx_n;
    logic [7:0]         csum, csum_n;
    logic [TMR_W-1:0]   timer, timer_n;
    logic               we_q, we_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic [INSTR_W-1:0] wdata_q, wdata_n;
    logic               done_q, done_n;
    logic               err_q, err_n;

    logic               pk_valid;
    logic [INSTR_W-1:0] pk_word;
    logic               pk_word_valid;
    logic               in_frame;
    logic               len_ok;

    // start also flushes a partially packed word so an aborted frame cannot leak bytes
    assign pk_valid = bus.rx_valid && !start && (state == DATA);

    byte_word_packer #(.INSTR_W(INSTR_W)) u_packer (
        .clk        (CLK),
        .rst_n      (RST_N),
        .clear      (start),
        .byte_valid (pk_valid),
        .byte_in    (bus.rx_data),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    assign in_frame = (state == LEN) || (state == DATA) || (state == CSUM);
    assign len_ok   = (bus.rx_data != 8'd0) && ({1'b0, bus.rx_data} <= 9'(DEPTH));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            len     <= '0;
            idx     <= '0;
            csum    <= '0;
            timer   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            len     <= len_n;
            idx     <= idx_n;
            csum    <= csum_n;
            timer   <= timer_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        len_n   = len;
        idx_n   = idx;
        csum_n  = csum;
        timer_n = timer;
        we_n    = 1'b0;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        done_n  = done_q;
        err_n   = err_q;

        if (start) begin
            state_n = WAIT_SYNC;
            len_n   = '0;
            idx_n   = '0;
            csum_n  = '0;
            timer_n = '0;
            done_n  = 1'b0;
            err_n   = 1'b0;
        end else if (bus.rx_valid) begin
            timer_n = '0;
            case (state)
                WAIT_SYNC: begin
                    if (bus.rx_data == SYNC_BYTE) state_n = LEN;
                end
                LEN: begin
                    if (len_ok) begin
                        state_n = DATA;
                        len_n   = LEN_W'(bus.rx_data);
                        idx_n   = '0;
                        csum_n  = '0;
                    end else begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end
                end
                DATA: begin
                    csum_n = csum ^ bus.rx_data;
                    if (pk_word_valid) begin
                        we_n    = 1'b1;
                        addr_n  = idx[ADDR_W-1:0];
                        wdata_n = pk_word;
                        idx_n   = idx + LEN_W'(1);
                        if (idx == len - LEN_W'(1)) state_n = CSUM;
                    end
                end
                CSUM: begin
                    if (bus.rx_data == csum) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (in_frame) begin
            // timer holds idle cycles since the last accepted byte; the next idle edge reaching the limit aborts
            if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                state_n = ERR;
                err_n   = 1'b1;
            end else begin
                timer_n = timer + TMR_W'(1);
            end
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign loading        = (state == WAIT_SYNC) || in_frame;
    assign load_done      = done_q;
    assign load_err       = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed checks of program_loader framing, checksum, timeout, abort and reset behaviour.
module tb_program_loader;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic loading, load_done, load_err;

    int checks = 0;
    int errors = 0;

    logic [4:0]  wr_addr[$];
    logic [15:0] wr_data[$];

    program_loader_if #(.INSTR_W(16), .ADDR_W(5)) bus ();

    program_loader #(
        .INSTR_W     (16),
        .ADDR_W      (5),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (100)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .start     (start),
        .bus       (bus),
        .loading   (loading),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.rx_data  = 8'hA5;
        bus.rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.rx_valid = 1'b0;
        checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bus.imem_we); end
        checks++; if (bus.imem_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.imem_addr); end
        checks++; if (bus.imem_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", bus.imem_wdata); end
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL reset_loading got %b exp 0", loading); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", load_done); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", load_err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL idle_loading got %b exp 0", loading); end
    endtask

    task automatic test_good_frame();
        pulse_start();
        checks++; if (loading !== 1'b1) begin errors++; $display("FAIL good_wait_loading got %b exp 1", loading); end
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL good_we_mid got %b exp 0", bus.imem_we); end
        send_byte(8'h34);
        checks++; if (bus.imem_we !== 1'b1) begin errors++; $display("FAIL good_we0 got %b exp 1", bus.imem_we); end
        checks++; if (bus.imem_addr !== 5'd0) begin errors++; $display("FAIL good_addr0 got %h exp 0", bus.imem_addr); end
        checks++; if (bus.imem_wdata !== 16'h1234) begin errors++; $display("FAIL good_data0 got %h exp 1234", bus.imem_wdata); end
        send_byte(8'hAB);
        checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL good_we_pulse got %b exp 0", bus.imem_we); end
        send_byte(8'hCD);
        checks++; if (bus.imem_we !== 1'b1) begin errors++; $display("FAIL good_we1 got %b exp 1", bus.imem_we); end
        checks++; if (bus.imem_addr !== 5'd1) begin errors++; $display("FAIL good_addr1 got %h exp 1", bus.imem_addr); end
        checks++; if (bus.imem_wdata !== 16'hABCD) begin errors++; $display("FAIL good_data1 got %h exp abcd", bus.imem_wdata); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL good_done_early got %b exp 0", load_done); end
        send_byte(8'h40);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL good_done got %b exp 1", load_done); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL good_err got %b exp 0", load_err); end
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL good_loading got %b exp 0", loading); end
        checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL good_writes got %0d exp 2", wr_addr.size()); end
    endtask

    task automatic test_bad_len();
        logic [7:0] lens [2];
        lens[0] = 8'h00;
        lens[1] = 8'h21;
        for (int i = 0; i < 2; i++) begin
            pulse_start();
            checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL badlen_start_done got %b exp 0", load_done); end
            send_byte(8'hA5);
            send_byte(lens[i]);
            send_byte(8'h12);
            send_byte(8'h34);
            send_byte(8'h26);
            checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL badlen_err len=%h got %b exp 1", lens[i], load_err); end
            checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL badlen_done len=%h got %b exp 0", lens[i], load_done); end
            checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL badlen_writes len=%h got %0d exp 0", lens[i], wr_addr.size()); end
        end
    endtask

    task automatic test_bad_csum();
        pulse_start();
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL badcs_start_err got %b exp 0", load_err); end
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h41);
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL badcs_err got %b exp 1", load_err); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL badcs_done got %b exp 0", load_done); end
        checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL badcs_writes got %0d exp 2", wr_addr.size()); end
    endtask

    task automatic test_timeout();
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (100) @(negedge clk);
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL tmo100_err got %b exp 1", load_err); end
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL tmo100_loading got %b exp 0", loading); end
        checks++; if (wr_addr.size() !== 1) begin errors++; $display("FAIL tmo100_writes got %0d exp 1", wr_addr.size()); end

        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (99) @(negedge clk);
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL tmo99_err got %b exp 0", load_err); end
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h40);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL tmo99_done got %b exp 1", load_done); end
        checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL tmo99_writes got %0d exp 2", wr_addr.size()); end
    endtask

    task automatic test_abort();
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        pulse_start();
        checks++; if (loading !== 1'b1) begin errors++; $display("FAIL abort_loading got %b exp 1", loading); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", load_done); end
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        checks++; if (bus.imem_we !== 1'b1) begin errors++; $display("FAIL abort_we got %b exp 1", bus.imem_we); end
        checks++; if (bus.imem_addr !== 5'd0) begin errors++; $display("FAIL abort_addr got %h exp 0", bus.imem_addr); end
        checks++; if (bus.imem_wdata !== 16'hDEAD) begin errors++; $display("FAIL abort_data got %h exp dead", bus.imem_wdata); end
        send_byte(8'h73);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL abort_done_after got %b exp 1", load_done); end
    endtask

    task automatic test_start_collision();
        start        = 1'b1;
        bus.rx_data  = 8'hA5;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'h73);
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL collide_done got %b exp 0", load_done); end
        checks++; if (loading !== 1'b1) begin errors++; $display("FAIL collide_loading got %b exp 1", loading); end
        checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL collide_writes got %0d exp 0", wr_addr.size()); end
    endtask

    task automatic test_len32();
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h20);
        for (int i = 0; i < 32; i++) begin
            send_byte(8'h10);
            send_byte(8'(i));
        end
        send_byte(8'h00);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL len32_done got %b exp 1", load_done); end
        checks++; if (wr_addr.size() !== 32) begin errors++; $display("FAIL len32_writes got %0d exp 32", wr_addr.size()); end
        for (int i = 0; i < 32 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== 5'(i) || wr_data[i] !== 16'h1000 + 16'(i)) begin
                errors++;
                $display("FAIL len32_word%0d got %h:%h exp %h:%h", i, wr_addr[i], wr_data[i], 5'(i), 16'h1000 + 16'(i));
            end
        end
    endtask

    task automatic test_reset_midframe();
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        bus.rx_data  = 8'h34;
        bus.rx_valid = 1'b1;
        rst_n        = 1'b0;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL rstmid_we got %b exp 0", bus.imem_we); end
        checks++; if (bus.imem_addr !== 5'd0) begin errors++; $display("FAIL rstmid_addr got %h exp 0", bus.imem_addr); end
        checks++; if (bus.imem_wdata !== 16'h0) begin errors++; $display("FAIL rstmid_wdata got %h exp 0", bus.imem_wdata); end
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL rstmid_loading got %b exp 0", loading); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", load_done); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b exp 0", load_err); end
        rst_n = 1'b1;
        send_byte(8'hAB);
        send_byte(8'hCD);
        repeat (3) @(negedge clk);
        checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL rstmid_writes got %0d exp 0", wr_addr.size()); end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_len();
        test_bad_csum();
        test_timeout();
        test_abort();
        test_start_collision();
        test_len32();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
